ttc_apb_if_lite: RTL and testbench

APB slave front end for the single-timer lite TTC. It sits directly upstream of the timer/counter lite block and drives that block's per-register write selects, write data and clear_interrupt. It also returns the block's register values on prdata. It tracks APB SETUP/ACCESS phases, decodes a 9-register word map, flags bad accesses with pslverr, and produces registered one-cycle strobes.

---
 rtl/ttc_apb_if_lite.sv | 134 +++++++++++++
 tb/tb_ttc_apb_if_lite.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ttc_apb_if_lite.sv
// APB slave front end for the single-timer lite TTC: decodes the 9-word register
// map, returns registered read data and issues registered one-cycle write/clear strobes.
module ttc_apb_if_lite #(
    parameter int ADDR_W = 8
) (
    input  logic              pclk,
    input  logic              n_p_reset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [15:0]       pwdata,
    output logic [15:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [15:0]       wr_data,
    output logic              clk_ctrl_reg_sel,
    output logic              cntr_ctrl_reg_sel,
    output logic              interval_reg_sel,
    output logic              match_1_reg_sel,
    output logic              match_2_reg_sel,
    output logic              match_3_reg_sel,
    output logic              intr_en_reg_sel,
    output logic              clear_interrupt,
    input  logic [6:0]        clk_ctrl_reg,
    input  logic [6:0]        cntr_ctrl_reg,
    input  logic [15:0]       counter_val_reg,
    input  logic [15:0]       interval_reg,
    input  logic [15:0]       match_1_reg,
    input  logic [15:0]       match_2_reg,
    input  logic [15:0]       match_3_reg,
    input  logic [5:0]        interrupt_reg,
    input  logic [5:0]        interrupt_en_reg
);

    localparam int WORD_W = ADDR_W - 2;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    localparam logic [WORD_W-1:0] W_CLK_CTRL  = WORD_W'(0);
    localparam logic [WORD_W-1:0] W_CNTR_CTRL = WORD_W'(1);
    localparam logic [WORD_W-1:0] W_COUNTER   = WORD_W'(2);
    localparam logic [WORD_W-1:0] W_INTERVAL  = WORD_W'(3);
    localparam logic [WORD_W-1:0] W_MATCH_1   = WORD_W'(4);
    localparam logic [WORD_W-1:0] W_MATCH_2   = WORD_W'(5);
    localparam logic [WORD_W-1:0] W_MATCH_3   = WORD_W'(6);
    localparam logic [WORD_W-1:0] W_INTR      = WORD_W'(7);
    localparam logic [WORD_W-1:0] W_INTR_EN   = WORD_W'(8);

    logic [1:0]        phase_q, phase_d;
    logic [15:0]       prdata_q;
    logic [15:0]       wr_data_q;
    logic [6:0]        sel_q;
    logic              clear_q;
    logic [WORD_W-1:0] word;
    logic [15:0]       rd_data;
    logic              rd_ok;
    logic [6:0]        wr_sel;
    logic              access_en;
    logic              addr_lsb_unused;

    assign word            = paddr[ADDR_W-1:2];
    assign addr_lsb_unused = ^paddr[1:0];

    // Sel bit order: clk_ctrl, cntr_ctrl, interval, match_1, match_2, match_3, intr_en.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        rd_data = 16'h0000;
        rd_ok   = 1'b1;
        wr_sel  = 7'b0000000;
        case (word)
            W_CLK_CTRL:  begin rd_data = {9'b0, clk_ctrl_reg};  wr_sel = 7'b0000001; end
            W_CNTR_CTRL: begin rd_data = {9'b0, cntr_ctrl_reg}; wr_sel = 7'b0000010; end
            W_COUNTER:   rd_data = counter_val_reg;
            W_INTERVAL:  begin rd_data = interval_reg;          wr_sel = 7'b0000100; end
            W_MATCH_1:   begin rd_data = match_1_reg;           wr_sel = 7'b0001000; end
            W_MATCH_2:   begin rd_data = match_2_reg;           wr_sel = 7'b0010000; end
            W_MATCH_3:   begin rd_data = match_3_reg;           wr_sel = 7'b0100000; end
            W_INTR:      rd_data = {10'b0, interrupt_reg};
            W_INTR_EN:   begin rd_data = {10'b0, interrupt_en_reg}; wr_sel = 7'b1000000; end
            default:     rd_ok = 1'b0;
        endcase
    end

    // phase_d is the bus phase of the current cycle; phase_q remembers the previous one.
    always_comb begin
        phase_d = IDLE;
        case (phase_q)
            IDLE:    phase_d = (psel && !penable) ? SETUP : IDLE;
            SETUP:   phase_d = ACCESS;
            ACCESS:  phase_d = (psel && !penable) ? SETUP : IDLE;
            default: phase_d = IDLE;
        endcase
    end

    assign access_en = (phase_d == ACCESS) && penable;
    assign pslverr   = access_en && (pwrite ? (wr_sel == 7'b0000000) : !rd_ok);

    always_ff @(posedge pclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!n_p_reset) begin
            phase_q   <= IDLE;
            prdata_q  <= 16'h0000;
            wr_data_q <= 16'h0000;
            sel_q     <= 7'b0000000;
            clear_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            if (phase_d == SETUP) begin
                prdata_q <= rd_data;
            end
            if (access_en && pwrite) begin
                wr_data_q <= pwdata;
            end
            sel_q   <= (access_en && pwrite) ? wr_sel : 7'b0000000;
            clear_q <= access_en && !pwrite && (word == W_INTR);
        end
    end

    assign prdata            = prdata_q;
    assign pready            = 1'b1;
    assign wr_data           = wr_data_q;
    assign clear_interrupt   = clear_q;
    assign clk_ctrl_reg_sel  = sel_q[0];
    assign cntr_ctrl_reg_sel = sel_q[1];
    assign interval_reg_sel  = sel_q[2];
    assign match_1_reg_sel   = sel_q[3];
    assign match_2_reg_sel   = sel_q[4];
    assign match_3_reg_sel   = sel_q[5];
    assign intr_en_reg_sel   = sel_q[6];

endmodule

// File: tb/tb_ttc_apb_if_lite.sv
// Directed bench for ttc_apb_if_lite: a table of single APB transfers plus
// hand-written sequences for reset, back-to-back, aborted and unqualified accesses.
module tb_ttc_apb_if_lite;

    logic        pclk;
    logic        n_p_reset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [15:0] pwdata;
    logic [15:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [15:0] wr_data;
    logic        clk_ctrl_reg_sel, cntr_ctrl_reg_sel, interval_reg_sel;
    logic        match_1_reg_sel, match_2_reg_sel, match_3_reg_sel, intr_en_reg_sel;
    logic        clear_interrupt;
    logic [6:0]  clk_ctrl_reg, cntr_ctrl_reg;
    logic [15:0] counter_val_reg, interval_reg, match_1_reg, match_2_reg, match_3_reg;
    logic [5:0]  interrupt_reg, interrupt_en_reg;
    logic [6:0]  sel_v;

    int checks = 0;
    int errors = 0;

    ttc_apb_if_lite #(.ADDR_W(8)) dut (
        .pclk(pclk), .n_p_reset(n_p_reset), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .wr_data(wr_data),
        .clk_ctrl_reg_sel(clk_ctrl_reg_sel), .cntr_ctrl_reg_sel(cntr_ctrl_reg_sel),
        .interval_reg_sel(interval_reg_sel), .match_1_reg_sel(match_1_reg_sel),
        .match_2_reg_sel(match_2_reg_sel), .match_3_reg_sel(match_3_reg_sel),
        .intr_en_reg_sel(intr_en_reg_sel), .clear_interrupt(clear_interrupt),
        .clk_ctrl_reg(clk_ctrl_reg), .cntr_ctrl_reg(cntr_ctrl_reg),
        .counter_val_reg(counter_val_reg), .interval_reg(interval_reg),
        .match_1_reg(match_1_reg), .match_2_reg(match_2_reg), .match_3_reg(match_3_reg),
        .interrupt_reg(interrupt_reg), .interrupt_en_reg(interrupt_en_reg)
    );

    // Bit order: {intr_en, match_3, match_2, match_1, interval, cntr_ctrl, clk_ctrl}.
    assign sel_v = {intr_en_reg_sel, match_3_reg_sel, match_2_reg_sel, match_1_reg_sel,
                    interval_reg_sel, cntr_ctrl_reg_sel, clk_ctrl_reg_sel};

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
        logic [6:0]  exp_sel;
        logic        exp_clr;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge pclk);
        #1;
    endtask

    // SETUP followed by a cycle with penable still low, then the bus goes idle.
    task automatic abort_xfer(input logic [7:0] addr, input string name);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = 16'hA5A5;
        next_cycle();
        @(negedge pclk);
        check({name, "_err"}, {31'b0, pslverr}, 32'h0);
        next_cycle();
        psel = 1'b0;
        @(negedge pclk);
        check({name, "_sel"}, {24'b0, sel_v, clear_interrupt}, 32'h0);
        next_cycle();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'h0C, 16'hBEEF, 16'h0000, 1'b0, 7'b0000100, 1'b0};
        vecs[1]  = '{1'b0, 8'h10, 16'h0000, 16'h1234, 1'b0, 7'b0000000, 1'b0};
        vecs[2]  = '{1'b0, 8'h04, 16'h0000, 16'h0055, 1'b0, 7'b0000000, 1'b0};
        vecs[3]  = '{1'b0, 8'h1C, 16'h0000, 16'h002A, 1'b0, 7'b0000000, 1'b1};
        vecs[4]  = '{1'b0, 8'h3C, 16'h0000, 16'h0000, 1'b1, 7'b0000000, 1'b0};
        vecs[5]  = '{1'b1, 8'h08, 16'h1111, 16'h0000, 1'b1, 7'b0000000, 1'b0};
        vecs[6]  = '{1'b1, 8'h24, 16'h2222, 16'h0000, 1'b1, 7'b0000000, 1'b0};
        vecs[7]  = '{1'b0, 8'h08, 16'h0000, 16'hC0DE, 1'b0, 7'b0000000, 1'b0};
        vecs[8]  = '{1'b0, 8'h20, 16'h0000, 16'h0015, 1'b0, 7'b0000000, 1'b0};
        vecs[9]  = '{1'b1, 8'h18, 16'h7777, 16'h0000, 1'b0, 7'b0100000, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 16'h0000, 16'h0011, 1'b0, 7'b0000000, 1'b0};
        vecs[11] = '{1'b1, 8'h1C, 16'h3333, 16'h0000, 1'b1, 7'b0000000, 1'b0};
        vecs[12] = '{1'b1, 8'h14, 16'h4444, 16'h0000, 1'b0, 7'b0010000, 1'b0};
        vecs[13] = '{1'b0, 8'h0E, 16'h0000, 16'h0A0B, 1'b0, 7'b0000000, 1'b0};

        clk_ctrl_reg    = 7'h11;   cntr_ctrl_reg = 7'h55;
        counter_val_reg = 16'hC0DE; interval_reg = 16'h0A0B;
        match_1_reg     = 16'h1234; match_2_reg  = 16'h5678; match_3_reg = 16'h9ABC;
        interrupt_reg   = 6'h2A;    interrupt_en_reg = 6'h15;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 16'h0000;

        n_p_reset = 1'b0;
        repeat (3) next_cycle();
        @(negedge pclk);
        check("rst_prdata", {16'b0, prdata}, 32'h0);
        check("rst_pslverr", {31'b0, pslverr}, 32'h0);
        check("rst_wr_data", {16'b0, wr_data}, 32'h0);
        check("rst_strobes", {24'b0, sel_v, clear_interrupt}, 32'h0);
        check("rst_pready", {31'b0, pready}, 32'h1);
        next_cycle();
        n_p_reset = 1'b1;
        next_cycle();

        for (int i = 0; i < 14; i++) begin
            psel = 1'b1; penable = 1'b0; pwrite = vecs[i].wr;
            paddr = vecs[i].addr; pwdata = vecs[i].wdata;
            @(negedge pclk);
            check($sformatf("v%0d_setup_err", i), {31'b0, pslverr}, 32'h0);
            next_cycle();
            penable = 1'b1;
            @(negedge pclk);
            check($sformatf("v%0d_access_err", i), {31'b0, pslverr}, {31'b0, vecs[i].exp_err});
            if (!vecs[i].wr)
                check($sformatf("v%0d_prdata", i), {16'b0, prdata}, {16'b0, vecs[i].exp_rdata});
            next_cycle();
            psel = 1'b0; penable = 1'b0; pwdata = 16'h0000;
            @(negedge pclk);
            check($sformatf("v%0d_sel", i), {25'b0, sel_v}, {25'b0, vecs[i].exp_sel});
            check($sformatf("v%0d_clear", i), {31'b0, clear_interrupt}, {31'b0, vecs[i].exp_clr});
            check($sformatf("v%0d_post_err", i), {31'b0, pslverr}, 32'h0);
            if (!vecs[i].wr)
                check($sformatf("v%0d_prdata_hold", i), {16'b0, prdata}, {16'b0, vecs[i].exp_rdata});
            if (vecs[i].exp_sel != 7'b0)
                check($sformatf("v%0d_wr_data", i), {16'b0, wr_data}, {16'b0, vecs[i].wdata});
            next_cycle();
            @(negedge pclk);
            check($sformatf("v%0d_pulse_end", i), {24'b0, sel_v, clear_interrupt}, 32'h0);
            next_cycle();
        end

        // Back-to-back writes: first strobe lands on the second transfer's SETUP.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 16'h0003;
        next_cycle();
        penable = 1'b1;
        next_cycle();
        penable = 1'b0; paddr = 8'h20; pwdata = 16'h003F;
        @(negedge pclk);
        check("b2b_clk_sel", {25'b0, sel_v}, 32'h01);
        check("b2b_wr_data_1", {16'b0, wr_data}, 32'h0003);
        next_cycle();
        penable = 1'b1;
        @(negedge pclk);
        check("b2b_gap", {25'b0, sel_v}, 32'h0);
        next_cycle();
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check("b2b_intr_en_sel", {25'b0, sel_v}, 32'h40);
        check("b2b_wr_data_2", {16'b0, wr_data}, 32'h003F);
        next_cycle();

        // ACCESS-looking cycle with no preceding SETUP is ignored.
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h08; pwdata = 16'h5555;
        @(negedge pclk);
        check("idle_access_err", {31'b0, pslverr}, 32'h0);
        next_cycle();
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check("idle_access_sel", {24'b0, sel_v, clear_interrupt}, 32'h0);
        next_cycle();

        abort_xfer(8'h0C, "abort_wr");
        abort_xfer(8'h08, "abort_ro");

        // Reset asserted during the ACCESS of a write drops its strobe.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 16'h1111;
        next_cycle();
        penable = 1'b1; n_p_reset = 1'b0;
        next_cycle();
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check("midrst_sel", {24'b0, sel_v, clear_interrupt}, 32'h0);
        check("midrst_prdata", {16'b0, prdata}, 32'h0);
        check("midrst_wr_data", {16'b0, wr_data}, 32'h0);
        check("midrst_pslverr", {31'b0, pslverr}, 32'h0);
        next_cycle();
        n_p_reset = 1'b1;
        @(negedge pclk);
        check("midrst_sel_after", {24'b0, sel_v, clear_interrupt}, 32'h0);
        check("midrst_wr_data_after", {16'b0, wr_data}, 32'h0);
        next_cycle();
        @(negedge pclk);
        check("midrst_sel_late", {24'b0, sel_v, clear_interrupt}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
